pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Upstream stage of the 4Kx8 program ROM: owns the 12-bit program counter that drives the ROM
//   address and captures the returned byte into an instruction/operand register pair.
//   Sits between the control logic (en/load) and the decoder; fetch rate is one byte per two clocks.
// PARAMETERS
//   ADDR_W   12   program counter / ROM address width
//   DATA_W   8    ROM data width; split into two DATA_W/2 nibbles
// PORTS
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous, active-low reset
//   en         in   1       run fetch sequence while high
//   load       in   1       synchronous PC load request
//   load_addr  in   ADDR_W  value for PC on load
//   rom_data   in   DATA_W  ROM Dout (combinational from rom_addr)
//   rom_addr   out  ADDR_W  current PC, registered, to ROM address
//   instr      out  DATA_W/2  rom_data[7:4] captured
//   oprnd      out  DATA_W/2  rom_data[3:0] captured
//   valid      out  1       instr/oprnd hold a newly fetched byte (one-cycle pulse)
//   halted     out  1       PC stopped at top of ROM (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=S_IDLE, rom_addr=0, instr=0, oprnd=0, valid=0, halted=0.
//   - States: S_IDLE, S_FETCH, S_EXEC, S_HALT (S_HALT reachable only with macro).
//   - S_IDLE: en=1 -> S_FETCH; else stay. Outputs hold.
//   - S_FETCH: rom_addr=PC for the whole cycle; on the edge: {instr,oprnd}<=rom_data,
//     PC<=PC+1, valid<=1, -> S_EXEC.
//   - S_EXEC: valid=1 this cycle only; on the edge valid<=0; en=1 -> S_FETCH, en=0 -> S_IDLE.
//   - Latency: byte at address A appears on instr/oprnd with valid one clock after the S_FETCH
//     cycle in which rom_addr=A; sustained throughput 1 byte / 2 clocks.
//   - load=1 (any state, incl. S_HALT): PC<=load_addr, valid<=0, halted<=0, -> S_FETCH if en
//     else S_IDLE. load has priority over en and over a same-cycle increment; instr/oprnd hold.
//   - Arithmetic: PC+1 modulo 2^ADDR_W; 4095+1 = 0 (default build).
//   - en dropping in S_FETCH does not abort: the capture completes, then S_EXEC -> S_IDLE.
//   - Reset mid-fetch: immediate return to reset values; no partial capture.
//   - instr/oprnd change only on a S_FETCH edge; stable otherwise.
// CONFIGURATION
//   PC_WRAP_HALT_EN defined: fetching address 2^ADDR_W-1 still captures and pulses valid, but
//     PC stays at 4095, halted<=1, state -> S_HALT; S_HALT ignores en; exits only via load or reset.
//   PC_WRAP_HALT_EN undefined: PC wraps 4095 -> 0, S_HALT unused, halted tied 0.
// STRUCTURE
//   - Shared package fetch_pkg: state encoding (S_IDLE=2'd0, S_FETCH=2'd1, S_EXEC=2'd2,
//     S_HALT=2'd3), ADDR_W/DATA_W defaults, PC_RESET=12'h000.
//   - One sub-module: program_counter (ADDR_W-bit register, async active-low reset, sync load
//     with priority, increment enable, wrap/terminal-count flag). FSM + capture reg in top.
// TESTING (bench instantiates ROM4Kx8 with known contents, or models rom_data)
//   1 Reset: hold reset_n=0 with en=1 -> rom_addr=000, instr=0, oprnd=0, valid=0, halted=0;
//     assert reset_n=0 mid-S_FETCH -> same values asynchronously.
//   2 Sequential fetch: ROM[0..2]=8'hA5,8'h3C,8'h0F, en=1 -> valid pulses every 2nd clock;
//     instr/oprnd = A/5, 3/C, 0/F; rom_addr 000->001->002->003.
//   3 Load: load=1, load_addr=12'h7F0 while in S_EXEC -> valid=0 next clock, rom_addr=7F0,
//     next capture is ROM[7F0]; load and en same cycle -> load wins.
//   4 en gating: drop en during S_FETCH -> capture completes, valid pulses once, then S_IDLE;
//     rom_addr holds at next address, no further valid.
//   5 Wrap (default): load 12'hFFE, en=1 -> captures FFE, FFF, then 000; halted stays 0.
//   6 Wrap (PC_WRAP_HALT_EN): load 12'hFFF -> one valid with ROM[FFF], halted=1, rom_addr=FFF,
//     en ignored; load 12'h000 -> halted=0, fetch resumes at 000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the program-ROM fetch stage: state encoding,
// default widths and the program counter reset value.
package fetch_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    localparam logic [11:0] PC_RESET = 12'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous load with priority over increment,
// modulo-2^ADDR_W increment, and a terminal-count flag when the PC is at
// the top address.
module program_counter #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              tc
);

    logic [ADDR_W-1:0] r_pc;

    // PC register: load beats increment; increment wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_VAL;
        end else if (load) begin
            r_pc <= load_addr;
        end else if (inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign pc = r_pc;
    assign tc = &r_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage in front of the 4Kx8 program ROM. Drives the ROM address from
// the program counter and captures each returned byte into an
// instruction/operand nibble pair, one byte every two clocks.
// Optional feature macro: PC_WRAP_HALT_EN -- when defined, fetching the top
// address parks the PC there and enters S_HALT instead of wrapping to 0.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                valid,
    output logic                halted
);

`ifdef PC_WRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic                w_pc_inc;
    logic                w_pc_tc;
    logic                w_capture;
    logic                w_valid_next;
    logic                w_halted_next;
    logic [ADDR_W-1:0]   w_pc;
    logic [DATA_W/2-1:0] r_instr;
    logic [DATA_W/2-1:0] r_oprnd;
    logic                r_valid;
    logic                r_halted;

    program_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (ADDR_W'(PC_RESET))
    ) u_pc (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_addr (load_addr),
        .inc       (w_pc_inc),
        .pc        (w_pc),
        .tc        (w_pc_tc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; load overrides everything, including
    // a capture that would otherwise happen in S_FETCH
    always_comb begin
        w_state_next  = r_state;
        w_pc_inc      = 1'b0;
        w_capture     = 1'b0;
        w_valid_next  = 1'b0;
        w_halted_next = r_halted;
        if (load) begin
            w_state_next  = en ? S_FETCH : S_IDLE;
            w_halted_next = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (en) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // capture always completes, even if en has dropped
                    w_capture    = 1'b1;
                    w_valid_next = 1'b1;
                    if (HALT_EN && w_pc_tc) begin
                        w_halted_next = 1'b1;
                        w_state_next  = S_HALT;
                    end else begin
                        w_pc_inc     = 1'b1;
                        w_state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_state_next = en ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    // parked at top of ROM; only load or reset leaves
                    w_state_next = HALT_EN ? S_HALT : S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Capture register and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr  <= '0;
            r_oprnd  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (w_capture) begin
                {r_instr, r_oprnd} <= rom_data;
            end
            r_valid  <= w_valid_next;
            r_halted <= w_halted_next;
        end
    end

    assign rom_addr = w_pc;
    assign instr    = r_instr;
    assign oprnd    = r_oprnd;
    assign valid    = r_valid;
    assign halted   = HALT_EN ? r_halted : 1'b0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed steps followed by a
// randomized run against a behavioural fetch model and an array ROM.
module tb_pc_fetch_unit;

`ifdef PC_WRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        load;
    logic [11:0] load_addr;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        valid;
    logic        halted;

    logic [7:0]  rom_mem [0:4095];

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .load      (load),
        .load_addr (load_addr),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .instr     (instr),
        .oprnd     (oprnd),
        .valid     (valid),
        .halted    (halted)
    );

    assign rom_data = rom_mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] e_addr, input logic e_valid,
                             input logic [7:0] e_byte, input logic e_halted);
        check({tag, ".rom_addr"}, 16'(rom_addr), 16'(e_addr));
        check({tag, ".valid"},    16'(valid),    16'(e_valid));
        check({tag, ".instr"},    16'(instr),    16'(e_byte[7:4]));
        check({tag, ".oprnd"},    16'(oprnd),    16'(e_byte[3:0]));
        check({tag, ".halted"},   16'(halted),   16'(e_halted));
        $display("step %-14s addr=%03h valid=%0b instr=%0h oprnd=%0h halted=%0b",
                 tag, rom_addr, valid, instr, oprnd, halted);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural model state: what the fetch stage should be showing
    logic [11:0] m_pc;
    logic        m_fetching;
    logic        m_valid;
    logic        m_halted;
    logic [7:0]  m_byte;

    // apply one clock of the fetch rules to the model
    task automatic model_edge(input logic i_en, input logic i_load, input logic [11:0] i_addr);
        if (i_load) begin
            m_pc       = i_addr;
            m_valid    = 1'b0;
            m_halted   = 1'b0;
            m_fetching = i_en;
        end else if (m_fetching) begin
            m_byte     = rom_mem[m_pc];
            m_valid    = 1'b1;
            m_fetching = 1'b0;
            if (HALT_EN && m_pc == 12'hFFF) begin
                m_halted = 1'b1;
            end else begin
                m_pc = (m_pc + 12'd1) % 13'd4096;
            end
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else begin
            m_valid    = 1'b0;
            m_fetching = i_en;
        end
    endtask

    logic [7:0] held;

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'hA5;
        rom_mem[1] = 8'h3C;
        rom_mem[2] = 8'h0F;

        // reset held with en high
        reset_n   = 1'b0;
        en        = 1'b1;
        load      = 1'b0;
        load_addr = 12'h000;
        step(); step(); step();
        check_all("reset", 12'h000, 1'b0, 8'h00, 1'b0);

        // sequential fetch of A5, 3C, 0F
        reset_n = 1'b1;
        step();
        check_all("seq_fetch0", 12'h000, 1'b0, 8'h00, 1'b0);
        step();
        check_all("seq_cap0", 12'h001, 1'b1, 8'hA5, 1'b0);
        step();
        check_all("seq_fetch1", 12'h001, 1'b0, 8'hA5, 1'b0);
        step();
        check_all("seq_cap1", 12'h002, 1'b1, 8'h3C, 1'b0);
        step();
        check_all("seq_fetch2", 12'h002, 1'b0, 8'h3C, 1'b0);
        step();
        check_all("seq_cap2", 12'h003, 1'b1, 8'h0F, 1'b0);

        // load during the valid cycle
        load      = 1'b1;
        load_addr = 12'h7F0;
        step();
        load = 1'b0;
        check_all("load_exec", 12'h7F0, 1'b0, 8'h0F, 1'b0);
        step();
        check_all("load_cap", 12'h7F1, 1'b1, rom_mem[12'h7F0], 1'b0);
        step();
        check_all("load_fetch", 12'h7F1, 1'b0, rom_mem[12'h7F0], 1'b0);

        // load with en in a fetch cycle: load wins, no capture, no increment
        load      = 1'b1;
        load_addr = 12'h123;
        step();
        load = 1'b0;
        check_all("load_win", 12'h123, 1'b0, rom_mem[12'h7F0], 1'b0);
        step();
        check_all("load_win_cap", 12'h124, 1'b1, rom_mem[12'h123], 1'b0);

        // drop en during a fetch: capture completes, then idle
        step();
        check_all("gate_fetch", 12'h124, 1'b0, rom_mem[12'h123], 1'b0);
        en = 1'b0;
        step();
        check_all("gate_cap", 12'h125, 1'b1, rom_mem[12'h124], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("gate_idle", 12'h125, 1'b0, rom_mem[12'h124], 1'b0);
        end

        // top of ROM
        en        = 1'b1;
        load      = 1'b1;
        load_addr = 12'hFFE;
        step();
        load = 1'b0;
        check_all("top_load", 12'hFFE, 1'b0, rom_mem[12'h124], 1'b0);
        step();
        check_all("top_capFFE", 12'hFFF, 1'b1, rom_mem[12'hFFE], 1'b0);
        step();
        check_all("top_fetchFFF", 12'hFFF, 1'b0, rom_mem[12'hFFE], 1'b0);
        step();
`ifdef PC_WRAP_HALT_EN
        check_all("halt_capFFF", 12'hFFF, 1'b1, rom_mem[12'hFFF], 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("halt_hold", 12'hFFF, 1'b0, rom_mem[12'hFFF], 1'b1);
        end
        load      = 1'b1;
        load_addr = 12'h000;
        step();
        load = 1'b0;
        check_all("halt_exit", 12'h000, 1'b0, rom_mem[12'hFFF], 1'b0);
        step();
        check_all("halt_resume", 12'h001, 1'b1, 8'hA5, 1'b0);
`else
        check_all("wrap_capFFF", 12'h000, 1'b1, rom_mem[12'hFFF], 1'b0);
        step();
        check_all("wrap_fetch0", 12'h000, 1'b0, rom_mem[12'hFFF], 1'b0);
        step();
        check_all("wrap_cap0", 12'h001, 1'b1, 8'hA5, 1'b0);
`endif

        // reset asserted in the middle of a fetch cycle
        step();
        held = HALT_EN ? 8'hA5 : 8'hA5;
        check_all("pre_rst_fetch", 12'h001, 1'b0, held, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("rst_async", 12'h000, 1'b0, 8'h00, 1'b0);
        step();
        check_all("rst_hold", 12'h000, 1'b0, 8'h00, 1'b0);

        // randomized run against the behavioural model
        en         = 1'b0;
        reset_n    = 1'b1;
        m_pc       = 12'h000;
        m_fetching = 1'b0;
        m_valid    = 1'b0;
        m_halted   = 1'b0;
        m_byte     = 8'h00;
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 9) < 7);
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                load_addr = 12'hFF0 + 12'($urandom_range(0, 15));
            else
                load_addr = 12'($urandom);
            model_edge(en, load, load_addr);
            step();
            check_all("rand", m_pc, m_valid, m_byte, m_halted);
        end
        load = 1'b0;
        en   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
